// File: rtl/hid_rx_fifo.sv
// Multi-channel HID scan-code receive FIFO with W1C overflow status and a registered 64-bit read port.
// Optional threshold interrupt and IRQ_CTRL register are built only when HID_IRQ_EN is defined.
module hid_rx_fifo #(
  parameter int NCHAN = 2,
  parameter int DEPTH = 16,
  parameter int DW    = 9
) (
  input  logic                  msoc_clk,
  input  logic                  rst,
  input  logic [NCHAN-1:0]      rx_ready,
  input  logic [NCHAN*DW-1:0]   rx_data,
  input  logic [NCHAN-1:0]      rx_err,
  input  logic                  hid_en,
  input  logic                  hid_we,
  input  logic [7:0]            hid_addr,
  input  logic [63:0]           hid_wrdata,
  output logic [63:0]           hid_rddata,
  output logic                  irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [4:0]    IRQ_W   = 5'(2 * NCHAN);

  logic [DW-1:0]    mem_q      [NCHAN][DEPTH];
  logic [AW-1:0]    wr_ptr_q   [NCHAN];
  logic [AW-1:0]    wr_ptr_d   [NCHAN];
  logic [AW-1:0]    rd_ptr_q   [NCHAN];
  logic [AW-1:0]    rd_ptr_d   [NCHAN];
  logic [CW-1:0]    count_q    [NCHAN];
  logic [CW-1:0]    count_d    [NCHAN];
  logic [NCHAN-1:0] ovf_q;
  logic [NCHAN-1:0] ovf_d;
  logic [NCHAN-1:0] rx_ready_q;
  logic [NCHAN-1:0] rx_ready_d;
  logic [63:0]      rddata_q;
  logic [63:0]      rddata_d;

  logic [4:0]       word_s;
  logic             rd_acc_s;
  logic             wr_acc_s;
  logic [NCHAN-1:0] push_s;
  logic [NCHAN-1:0] pop_s;
  logic [NCHAN-1:0] accept_s;
  logic [NCHAN-1:0] full_s;
  logic [NCHAN-1:0] empty_s;
  logic [NCHAN-1:0] ovf_clr_s;
  logic [63:0]      rd_word_s;

`ifdef HID_IRQ_EN
  logic [7:0] irq_en_q;
  logic [7:0] irq_en_d;
  logic [8:0] irq_thr_q;
  logic [8:0] irq_thr_d;
  logic       irq_q;
  logic       irq_d;
  logic       unused_s;
  assign unused_s = ^{hid_wrdata[63:25], hid_wrdata[17:8], hid_addr[2:0]};
`else
  logic       unused_s;
  assign unused_s = ^{hid_wrdata[63:19], hid_wrdata[17:0], hid_addr[2:0]};
`endif

  // Bus decode, per-channel push/pop arbitration and next-state for pointers, counts and overflow.
  always_comb begin
    word_s     = hid_addr[7:3];
    rd_acc_s   = hid_en & ~hid_we;
    wr_acc_s   = hid_en & hid_we;
    rx_ready_d = rx_ready;
    for (int c = 0; c < NCHAN; c++) begin
      push_s[c]    = rx_ready[c] & ~rx_ready_q[c];
      empty_s[c]   = (count_q[c] == '0);
      full_s[c]    = (count_q[c] == DEPTH_C);
      pop_s[c]     = rd_acc_s & (word_s == 5'(2 * c)) & ~empty_s[c];
      // A full FIFO still accepts a push when the same cycle pops.
      accept_s[c]  = push_s[c] & (~full_s[c] | pop_s[c]);
      ovf_clr_s[c] = wr_acc_s & (word_s == 5'(2 * c + 1)) & hid_wrdata[18];
      ovf_d[c]     = (push_s[c] & full_s[c] & ~pop_s[c]) | (ovf_q[c] & ~ovf_clr_s[c]);
      wr_ptr_d[c]  = accept_s[c] ? wr_ptr_q[c] + AW'(1) : wr_ptr_q[c];
      rd_ptr_d[c]  = pop_s[c] ? rd_ptr_q[c] + AW'(1) : rd_ptr_q[c];
      count_d[c]   = count_q[c] + {{(CW-1){1'b0}}, accept_s[c]} - {{(CW-1){1'b0}}, pop_s[c]};
    end
  end

  // Read mux over the register map, sampled from pre-update state.
  always_comb begin
    rd_word_s = 64'd0;
    for (int c = 0; c < NCHAN; c++) begin
      if (word_s == 5'(2 * c)) begin
        rd_word_s[DW-1:0] = empty_s[c] ? {DW{1'b0}} : mem_q[c][rd_ptr_q[c]];
        rd_word_s[DW]     = empty_s[c];
        rd_word_s[DW+1]   = rx_err[c];
      end else if (word_s == 5'(2 * c + 1)) begin
        rd_word_s[15:0] = 16'(count_q[c]);
        rd_word_s[16]   = empty_s[c];
        rd_word_s[17]   = full_s[c];
        rd_word_s[18]   = ovf_q[c];
        rd_word_s[19]   = rx_err[c];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
`ifdef HID_IRQ_EN
    if (word_s == IRQ_W) begin
      rd_word_s[7:0]   = irq_en_q;
      rd_word_s[24:16] = irq_thr_q;
    end else begin
      rd_word_s = rd_word_s;
    end
`endif
    rddata_d = rd_acc_s ? rd_word_s : rddata_q;
  end

  // FIFO storage; contents need no reset because counts gate every read.
  always_ff @(posedge msoc_clk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (accept_s[c]) begin
        mem_q[c][wr_ptr_q[c]] <= rx_data[c*DW +: DW];
      end
    end
  end

  // Control state; rx_ready_q tracks the input even in reset to avoid a push on release.
  always_ff @(posedge msoc_clk) begin
    rx_ready_q <= rx_ready_d;
    if (rst) begin
      for (int c = 0; c < NCHAN; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      ovf_q    <= '0;
      rddata_q <= 64'd0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
      end
      ovf_q    <= ovf_d;
      rddata_q <= rddata_d;
    end
  end

  assign hid_rddata = rddata_q;

`ifdef HID_IRQ_EN
  // IRQ_CTRL update and threshold/overflow interrupt condition.
  always_comb begin
    if (wr_acc_s && (word_s == IRQ_W)) begin
      irq_en_d  = hid_wrdata[7:0];
      irq_thr_d = hid_wrdata[24:16];
    end else begin
      irq_en_d  = irq_en_q;
      irq_thr_d = irq_thr_q;
    end
    irq_d = 1'b0;
    for (int c = 0; c < NCHAN; c++) begin
      if (irq_en_q[c] && (((16'(count_q[c]) >= 16'(irq_thr_q)) && (irq_thr_q != 9'd0)) || ovf_q[c])) begin
        irq_d = 1'b1;
      end else begin
        irq_d = irq_d;
      end
    end
  end

  // Interrupt control registers.
  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      irq_en_q  <= 8'd0;
      irq_thr_q <= 9'd0;
      irq_q     <= 1'b0;
    end else begin
      irq_en_q  <= irq_en_d;
      irq_thr_q <= irq_thr_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_hid_rx_fifo.sv
// Self-checking bench for hid_rx_fifo (NCHAN=2, DEPTH=16, DW=9) using a per-channel queue scoreboard.
module tb_hid_rx_fifo;

  logic        msoc_clk;
  logic        rst;
  logic [1:0]  rx_ready;
  logic [17:0] rx_data;
  logic [1:0]  rx_err;
  logic        hid_en;
  logic        hid_we;
  logic [7:0]  hid_addr;
  logic [63:0] hid_wrdata;
  logic [63:0] hid_rddata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [1:0] m_ovf;

  hid_rx_fifo #(.NCHAN(2), .DEPTH(16), .DW(9)) dut (
    .msoc_clk  (msoc_clk),
    .rst       (rst),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .hid_en    (hid_en),
    .hid_we    (hid_we),
    .hid_addr  (hid_addr),
    .hid_wrdata(hid_wrdata),
    .hid_rddata(hid_rddata),
    .irq       (irq)
  );

  initial msoc_clk = 1'b0;
  always #5 msoc_clk = ~msoc_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge msoc_clk);
    #1;
  endtask

  function automatic int msize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  task automatic m_push(input int c, input logic [8:0] d);
    if (msize(c) < 16) begin
      if (c == 0) q0.push_back(d);
      else        q1.push_back(d);
    end else begin
      m_ovf[c] = 1'b1;
    end
  endtask

  task automatic m_read(input int c, output logic [63:0] w);
    w = 64'd0;
    w[10] = rx_err[c];
    if (msize(c) == 0) begin
      w[9] = 1'b1;
    end else if (c == 0) begin
      w[8:0] = q0.pop_front();
    end else begin
      w[8:0] = q1.pop_front();
    end
  endtask

  function automatic logic [63:0] m_status(input int c);
    logic [63:0] w;
    w = 64'd0;
    w[15:0] = 16'(msize(c));
    w[16] = (msize(c) == 0);
    w[17] = (msize(c) == 16);
    w[18] = m_ovf[c];
    w[19] = rx_err[c];
    return w;
  endfunction

  task automatic do_push(input int c, input logic [8:0] d);
    rx_data[c*9 +: 9] = d;
    rx_ready[c] = 1'b1;
    tick();
    m_push(c, d);
    rx_ready[c] = 1'b0;
    tick();
  endtask

  task automatic read_data(input int c, input int n, input string tag);
    logic [63:0] e;
    hid_en = 1'b1; hid_we = 1'b0; hid_addr = {5'(2 * c), 3'b000};
    for (int i = 0; i < n; i++) begin
      tick();
      m_read(c, e);
      check(tag, hid_rddata, e);
    end
    hid_en = 1'b0;
  endtask

  task automatic read_status(input int c, input string tag);
    hid_en = 1'b1; hid_we = 1'b0; hid_addr = {5'(2 * c + 1), 3'b000};
    tick();
    hid_en = 1'b0;
    check(tag, hid_rddata, m_status(c));
`ifndef HID_IRQ_EN
    check({tag, "_irq"}, {63'd0, irq}, 64'd0);
`endif
  endtask

  task automatic read_word(input logic [4:0] w, input logic [63:0] exp, input string tag);
    hid_en = 1'b1; hid_we = 1'b0; hid_addr = {w, 3'b000};
    tick();
    hid_en = 1'b0;
    check(tag, hid_rddata, exp);
  endtask

  task automatic write_reg(input logic [4:0] w, input logic [63:0] d);
    hid_en = 1'b1; hid_we = 1'b1; hid_addr = {w, 3'b000}; hid_wrdata = d;
    tick();
    hid_en = 1'b0; hid_we = 1'b0; hid_wrdata = 64'd0;
  endtask

  initial begin
    logic [63:0] e;
    rst = 1'b1; rx_ready = 2'b11; rx_data = 18'd0; rx_err = 2'b00;
    hid_en = 1'b0; hid_we = 1'b0; hid_addr = 8'd0; hid_wrdata = 64'd0;
    m_ovf = 2'b00;
    repeat (3) tick();
    check("rst_rddata", hid_rddata, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("post_rst_rddata", hid_rddata, 64'd0);
    read_status(0, "rst_status0");
    read_status(1, "rst_status1");
    rx_ready = 2'b00;
    tick();

    // FIFO order and empty read
    do_push(0, 9'h01C);
    do_push(0, 9'h11C);
    do_push(0, 9'h0F0);
    read_status(0, "order_status");
    read_data(0, 4, "order_data");

    // Overflow on channel 1
    for (int i = 1; i <= 17; i++) do_push(1, 9'(i));
    read_status(1, "ovf_status");

    // Full FIFO: push and pop together
    rx_data[9 +: 9] = 9'h0AA; rx_ready[1] = 1'b1;
    hid_en = 1'b1; hid_we = 1'b0; hid_addr = {5'd2, 3'b000};
    tick();
    m_read(1, e);
    m_push(1, 9'h0AA);
    check("full_pushpop_rd", hid_rddata, e);
    rx_ready[1] = 1'b0; hid_en = 1'b0;
    tick();
    read_status(1, "full_pushpop_status");

    // W1C overflow clear, then drain
    write_reg(5'd3, 64'h0000_0000_0004_0000);
    m_ovf[1] = 1'b0;
    read_status(1, "w1c_status");
    read_data(1, 17, "drain1");

    // Empty FIFO: push and read together
    rx_data[0 +: 9] = 9'h055; rx_ready[0] = 1'b1;
    hid_en = 1'b1; hid_we = 1'b0; hid_addr = {5'd0, 3'b000};
    tick();
    m_read(0, e);
    m_push(0, 9'h055);
    check("empty_pushpop_rd", hid_rddata, e);
    rx_ready[0] = 1'b0; hid_en = 1'b0;
    tick();
    read_data(0, 2, "empty_pushpop_next");

    // Channel isolation with rx_err on channel 1
    rx_err = 2'b10;
    for (int i = 0; i < 5; i++) begin
      do_push(0, 9'($urandom_range(0, 511)));
      do_push(1, 9'($urandom_range(0, 511)));
    end
    read_status(0, "iso_status0");
    read_status(1, "iso_status1");
    read_data(0, 6, "iso_data0");
    read_data(1, 6, "iso_data1");
    rx_err = 2'b00;

    // Writes to DATA and unmapped words are ignored; unmapped reads return 0
    do_push(0, 9'h1A5);
    write_reg(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    read_status(0, "data_wr_ignored");
    read_word(5'd5, 64'd0, "unmapped5");
    read_word(5'd31, 64'd0, "unmapped31");
    read_data(0, 1, "data_after_wr");

    // Overflow set beats W1C clear in the same cycle
    for (int i = 0; i < 16; i++) do_push(1, 9'(i + 100));
    rx_data[9 +: 9] = 9'h1FF; rx_ready[1] = 1'b1;
    hid_en = 1'b1; hid_we = 1'b1; hid_addr = {5'd3, 3'b000}; hid_wrdata = 64'h0000_0000_0004_0000;
    tick();
    m_push(1, 9'h1FF);
    rx_ready[1] = 1'b0; hid_en = 1'b0; hid_we = 1'b0; hid_wrdata = 64'd0;
    tick();
    read_status(1, "set_wins");

    // Reset mid-operation
    do_push(0, 9'h033);
    read_status(0, "pre_rst_status");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete(); q1.delete(); m_ovf = 2'b00;
    check("midrst_rddata", hid_rddata, 64'd0);
    read_status(0, "midrst_status0");
    read_status(1, "midrst_status1");

`ifdef HID_IRQ_EN
    write_reg(5'd4, 64'h0000_0000_0004_0001);
    read_word(5'd4, 64'h0000_0000_0004_0001, "irq_ctrl_rd");
    for (int i = 0; i < 3; i++) do_push(0, 9'(i + 1));
    check("irq_below_thr", {63'd0, irq}, 64'd0);
    rx_data[0 +: 9] = 9'h004; rx_ready[0] = 1'b1;
    tick();
    m_push(0, 9'h004);
    check("irq_at_push", {63'd0, irq}, 64'd0);
    rx_ready[0] = 1'b0;
    tick();
    check("irq_set", {63'd0, irq}, 64'd1);
    read_data(0, 1, "irq_pop");
    check("irq_hold", {63'd0, irq}, 64'd1);
    tick();
    check("irq_clear", {63'd0, irq}, 64'd0);
`else
    write_reg(5'd4, 64'h0000_0000_0004_0001);
    read_word(5'd4, 64'd0, "irq_ctrl_absent");
    for (int i = 0; i < 4; i++) do_push(0, 9'(i + 1));
    tick();
    check("irq_tied", {63'd0, irq}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hid_rx_fifo.md
# hid_rx_fifo

Parametrised multi-channel receive buffer for HID scan codes. It generalises the single keyboard FIFO in the HID subsystem to NCHAN channels (keyboard, mouse, …) of configurable depth and entry width. Each channel has sticky overflow tracking and a W1C status register. The block sits between the PS/2 receivers and the `hid_en`/`hid_addr` memory-mapped bus on `msoc_clk`, and presents a registered 64-bit read port. An optional threshold interrupt is available.

## Interface
Parameters:
- NCHAN, 2 — number of receive channels, 1..8
- DEPTH, 16 — entries per channel FIFO; power of two, 2..512
- DW, 9 — entry width: {released, scan_code[7:0]}; 1..48

Ports:
- msoc_clk  in  1  — single clock; every register is rising-edge on it
- rst  in  1  — synchronous reset, active-high
- rx_ready  in  NCHAN  — per-channel "code ready" level from the receiver; a 0→1 edge pushes one entry
- rx_data  in  NCHAN*DW  — channel c occupies bits [c*DW +: DW]; sampled on the push cycle
- rx_err  in  NCHAN  — per-channel no-ack error level; reported only, never stored
- hid_en  in  1  — bus access strobe, one cycle per access
- hid_we  in  1  — 1 = write, 0 = read
- hid_addr  in  8  — byte address; word index w = hid_addr[7:3]
- hid_wrdata  in  64  — write data
- hid_rddata  out  64  — registered read data
- irq  out  1  — level interrupt; present only under HID_IRQ_EN, otherwise constant 0

## Operation
Register map, all 64-bit:
- w = 2c, DATA_c (read pops):
  - bits [DW-1:0] = head entry; 0 when the FIFO is empty
  - bit [DW] = empty
  - bit [DW+1] = rx_err[c]
  - writes are ignored
- w = 2c+1, STATUS_c (read does not pop):
  - [15:0] = count
  - [16] = empty
  - [17] = full
  - [18] = overflow, sticky; write 1 to clear via hid_wrdata[18]
  - [19] = rx_err[c]
- w = 2*NCHAN, IRQ_CTRL (under the macro only): [7:0] = per-channel enable, [24:16] = threshold
- Any other w reads 0; writes to it are ignored.

Per-channel FIFO:
- Write/read pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, 0..DEPTH.
- Edge detector: rx_ready_q[c] <= rx_ready[c]; push = rx_ready[c] & ~rx_ready_q[c].
- Pop is a read access (hid_en & ~hid_we) to DATA_c while count ≠ 0.
- Push on a full FIFO: the entry is dropped, overflow is set, and nothing else changes. Exception: if a pop happens in the same cycle, the push is accepted and count stays DEPTH.
- Push and pop in the same cycle with count in 1..DEPTH-1: both take effect and count is unchanged.
- Push to an empty FIFO in the same cycle as a DATA read: the read returns empty=1 with data 0, the push lands, and count becomes 1.
- Overflow set and W1C clear in the same cycle: set wins.
- Reset mid-operation clears pointers, counts, overflow and hid_rddata, and empties the FIFO. rx_ready_q loads rx_ready during reset, so a level that is already high causes no spurious push after release.

## Timing
- Reset values: hid_rddata = 0, irq = 0, all counts = 0, all overflow = 0, IRQ_CTRL = 0.
- A push at edge T is visible in count and in DATA reads issued from cycle T+1.
- Read latency is 1: an access in cycle T gives hid_rddata at T+1, held until the next read. The pop pointer advances at the same edge.
- Back-to-back DATA reads, one per cycle, return consecutive entries.
- STATUS/IRQ_CTRL write effects are visible the cycle after the write.
- hid_rddata reflects state before that cycle's push/pop/clear (read-before-update).

## Configuration
- HID_IRQ_EN defined:
  - IRQ_CTRL exists.
  - irq is registered: irq <= OR over c of en[c] & ((count_c >= threshold & threshold ≠ 0) | overflow_c).
  - irq asserts 1 cycle after the condition becomes true and deasserts 1 cycle after it clears.
- HID_IRQ_EN undefined:
  - No IRQ_CTRL storage; w = 2*NCHAN reads 0 and writes are ignored.
  - irq is tied to 0.

## Test plan
- Reset: hold rst with rx_ready=1. Release, wait 5 cycles → STATUS_0 count=0, empty=1, hid_rddata=0, no push recorded.
- Order: pulse rx_ready[0] three times with data 0x01C, 0x11C, 0x0F0, then read DATA_0 four times back-to-back → 0x01C, 0x11C, 0x0F0, then bit[DW]=1 with data 0.
- Overflow (DEPTH=16): 17 pushes on channel 1 → count=16, full=1, overflow=1. The 17th entry is lost, and draining returns entries 1..16. Write STATUS_1 with bit 18 set → overflow=0.
- Simultaneous events: FIFO full, push and DATA read in the same cycle → count stays 16 and the new entry comes out last. FIFO empty, push plus read in the same cycle → read returns empty=1 and the next read returns the new entry.
- Channel isolation: interleaved pushes on channels 0 and 1 → each DATA_c returns only its own codes in order. rx_err[1]=1 → STATUS_1[19]=1 and STATUS_0[19]=0.
- HID_IRQ_EN: set en=0x01 and threshold=4, then push 4 codes on channel 0 → irq=1 one cycle after the 4th push; one DATA read → irq=0 one cycle later. Without the macro, irq stays 0.
